// File: rtl/spectag_resolver_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spectag_resolver_pkg
// Description : Shared sizing constants for the speculative-tag resolver.
//               SPECTAG_LEN is the one-hot tag width; it is always one wider
//               than the branch queue depth (one tag per outstanding branch
//               plus the non-speculative tag).
// Contents    : SPECTAG_LEN, BRANCH_ENT_NUM, BRDEPTH_LEN, ADDR_LEN, ptr_width()
// Revision    : 1.0 - initial release
// ============================================================================
package spectag_resolver_pkg;

  localparam int BRANCH_ENT_NUM = 4;
  localparam int SPECTAG_LEN    = BRANCH_ENT_NUM + 1;
  localparam int ADDR_LEN       = 32;

  // Pointer width for an n-entry circular queue; never narrower than 1 bit
  // so a single-entry queue still has a legal pointer register.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int BRDEPTH_LEN = ptr_width(BRANCH_ENT_NUM);

endpackage : spectag_resolver_pkg
`default_nettype wire

// File: rtl/spectag_resolver_if.sv
`default_nettype none
// ============================================================================
// Module      : spectag_resolver_if
// Description : Dispatch, execution-outcome and retire-feedback bundle of the
//               speculative-tag resolver.
// Ports       : master - drives dispatch (enable, branchvalid1/2, tagreg,
//                        sptag1/2) and outcomes (exe_*); observes feedback.
//               slave  - the resolver; drives prsuccess, prmiss, tagregfix,
//                        kill_mask, prmiss_pc, empty, overflow.
// Revision    : 1.0 - initial release
// ============================================================================
interface spectag_resolver_if
  import spectag_resolver_pkg::*;
#(
  parameter int TAG_LEN = SPECTAG_LEN,
  parameter int ADDR_W  = ADDR_LEN
);

  // Dispatch side
  logic               enable;
  logic               branchvalid1;
  logic               branchvalid2;
  logic [TAG_LEN-1:0] tagreg;
  logic [TAG_LEN-1:0] sptag1;
  logic [TAG_LEN-1:0] sptag2;
  // Execution outcome
  logic               exe_valid;
  logic [TAG_LEN-1:0] exe_tag;
  logic               exe_miss;
  logic [ADDR_W-1:0]  exe_target;
  // Retire feedback
  logic               prsuccess;
  logic               prmiss;
  logic [TAG_LEN-1:0] tagregfix;
  logic [TAG_LEN-1:0] kill_mask;
  logic [ADDR_W-1:0]  prmiss_pc;
  logic               empty;
  logic               overflow;

  modport master (
    output enable, branchvalid1, branchvalid2, tagreg, sptag1, sptag2,
    output exe_valid, exe_tag, exe_miss, exe_target,
    input  prsuccess, prmiss, tagregfix, kill_mask, prmiss_pc, empty, overflow
  );

  modport slave (
    input  enable, branchvalid1, branchvalid2, tagreg, sptag1, sptag2,
    input  exe_valid, exe_tag, exe_miss, exe_target,
    output prsuccess, prmiss, tagregfix, kill_mask, prmiss_pc, empty, overflow
  );

endinterface : spectag_resolver_if
`default_nettype wire

// File: rtl/spectag_resolver_brq_entry.sv
`default_nettype none
// ============================================================================
// Module      : brq_entry
// Description : One branch-queue entry: holds {valid, own, parent, resolved,
//               miss, target}, CAM-compares its own tag against the execution
//               outcome and records it on a match.
// Ports       : clk, reset (async active-low)
//               flush_i  - clear (mispredict flush)
//               alloc_i  - load a new branch (alloc_own_i / alloc_parent_i)
//               pop_i    - clear after a correct retire
//               exe_*_i  - execution outcome broadcast
//               *_o      - registered entry fields
// Revision    : 1.0 - initial release
// ============================================================================
module brq_entry
  import spectag_resolver_pkg::*;
#(
  parameter int TAG_LEN = SPECTAG_LEN,
  parameter int ADDR_W  = ADDR_LEN
) (
  input  wire logic               clk,
  input  wire logic               reset,
  input  wire logic               flush_i,
  input  wire logic               alloc_i,
  input  wire logic [TAG_LEN-1:0] alloc_own_i,
  input  wire logic [TAG_LEN-1:0] alloc_parent_i,
  input  wire logic               pop_i,
  input  wire logic               exe_valid_i,
  input  wire logic [TAG_LEN-1:0] exe_tag_i,
  input  wire logic               exe_miss_i,
  input  wire logic [ADDR_W-1:0]  exe_target_i,
  output logic                    valid_o,
  output logic [TAG_LEN-1:0]      own_o,
  output logic [TAG_LEN-1:0]      parent_o,
  output logic                    resolved_o,
  output logic                    miss_o,
  output logic [ADDR_W-1:0]       target_o
);

  logic               valid_q,    valid_d;
  logic [TAG_LEN-1:0] own_q,      own_d;
  logic [TAG_LEN-1:0] parent_q,   parent_d;
  logic               resolved_q, resolved_d;
  logic               miss_q,     miss_d;
  logic [ADDR_W-1:0]  target_q,   target_d;
  logic               w_match;

  assign w_match = valid_q && exe_valid_i && (own_q == exe_tag_i);

  // Alloc outranks pop: on a full queue that retires and dispatches in the
  // same cycle, the freed head slot is exactly where the new branch lands.
  always_comb begin
    valid_d    = valid_q;
    own_d      = own_q;
    parent_d   = parent_q;
    resolved_d = resolved_q;
    miss_d     = miss_q;
    target_d   = target_q;
    if (flush_i) begin
      valid_d    = 1'b0;
      resolved_d = 1'b0;
      miss_d     = 1'b0;
    end else if (alloc_i) begin
      valid_d    = 1'b1;
      own_d      = alloc_own_i;
      parent_d   = alloc_parent_i;
      resolved_d = 1'b0;
      miss_d     = 1'b0;
    end else if (pop_i) begin
      valid_d    = 1'b0;
      resolved_d = 1'b0;
      miss_d     = 1'b0;
    end else if (w_match) begin
      // A repeated outcome simply overwrites the earlier one.
      resolved_d = 1'b1;
      miss_d     = exe_miss_i;
      target_d   = exe_target_i;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q    <= 1'b0;
      own_q      <= '0;
      parent_q   <= '0;
      resolved_q <= 1'b0;
      miss_q     <= 1'b0;
      target_q   <= '0;
    end else begin
      valid_q    <= valid_d;
      own_q      <= own_d;
      parent_q   <= parent_d;
      resolved_q <= resolved_d;
      miss_q     <= miss_d;
      target_q   <= target_d;
    end
  end

  assign valid_o    = valid_q;
  assign own_o      = own_q;
  assign parent_o   = parent_q;
  assign resolved_o = resolved_q;
  assign miss_o     = miss_q;
  assign target_o   = target_q;

endmodule : brq_entry
`default_nettype wire

// File: rtl/spectag_resolver.sv
`default_nettype none
// ============================================================================
// Module      : spectag_resolver
// Description : Branch queue that records dispatched speculative branches,
//               collects out-of-order outcomes and retires oldest-first,
//               producing prsuccess / prmiss / tagregfix feedback plus a
//               kill mask and redirect PC.
// Ports       : clk   - clock
//               reset - asynchronous, active-low
//               bus   - spectag_resolver_if.slave (dispatch, outcome,
//                       retire feedback, empty, overflow)
// Revision    : 1.0 - initial release
// ============================================================================
module spectag_resolver
  import spectag_resolver_pkg::*;
#(
  parameter int SPECTAG_LEN    = spectag_resolver_pkg::SPECTAG_LEN,
  parameter int BRANCH_ENT_NUM = spectag_resolver_pkg::BRANCH_ENT_NUM,
  parameter int ADDR_LEN       = spectag_resolver_pkg::ADDR_LEN
) (
  input  wire logic         clk,
  input  wire logic         reset,
  spectag_resolver_if.slave bus
);

  localparam int PTR_LEN = ptr_width(BRANCH_ENT_NUM);
  localparam int CNT_LEN = $clog2(BRANCH_ENT_NUM + 1);
  localparam logic [PTR_LEN-1:0] LAST_PTR = PTR_LEN'(BRANCH_ENT_NUM - 1);

  function automatic logic [PTR_LEN-1:0] ptr_inc(input logic [PTR_LEN-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  logic [PTR_LEN-1:0] head_q, head_d;
  logic [PTR_LEN-1:0] tail_q, tail_d;
  logic [CNT_LEN-1:0] count_q, count_d;
  logic               overflow_q, overflow_d;

  logic                   ent_valid    [BRANCH_ENT_NUM];
  logic [SPECTAG_LEN-1:0] ent_own      [BRANCH_ENT_NUM];
  logic [SPECTAG_LEN-1:0] ent_parent   [BRANCH_ENT_NUM];
  logic                   ent_resolved [BRANCH_ENT_NUM];
  logic                   ent_miss     [BRANCH_ENT_NUM];
  logic [ADDR_LEN-1:0]    ent_target   [BRANCH_ENT_NUM];

  logic                   w_alloc      [BRANCH_ENT_NUM];
  logic [SPECTAG_LEN-1:0] w_alloc_own  [BRANCH_ENT_NUM];
  logic [SPECTAG_LEN-1:0] w_alloc_par  [BRANCH_ENT_NUM];

  logic                   w_retire_ok;
  logic                   w_retire_miss;
  logic [SPECTAG_LEN-1:0] w_kill;
  logic [PTR_LEN-1:0]     w_wr_ptr;
  logic                   w_drop;
  int                     w_space;
  int                     w_n_push;

  // Retire decision looks only at registered head state.
  assign w_retire_ok   = ent_valid[head_q] && ent_resolved[head_q] && !ent_miss[head_q];
  assign w_retire_miss = ent_valid[head_q] && ent_resolved[head_q] &&  ent_miss[head_q];

  always_comb begin
    w_kill = '0;
    for (int i = 0; i < BRANCH_ENT_NUM; i++) begin
      if (ent_valid[i]) w_kill = w_kill | ent_own[i];
    end
  end

  // Push placement. A slot retiring this cycle counts as free, so a full
  // queue can still accept a branch while prsuccess is high. Slot 2 is only
  // considered after slot 1, so slot order is preserved when space runs out.
  always_comb begin
    for (int i = 0; i < BRANCH_ENT_NUM; i++) begin
      w_alloc[i]     = 1'b0;
      w_alloc_own[i] = '0;
      w_alloc_par[i] = '0;
    end
    w_space  = BRANCH_ENT_NUM - int'(count_q) + (w_retire_ok ? 1 : 0);
    w_n_push = 0;
    w_drop   = 1'b0;
    w_wr_ptr = tail_q;
    if (bus.enable && !w_retire_miss) begin
      if (bus.branchvalid1) begin
        if (w_n_push < w_space) begin
          w_alloc[w_wr_ptr]     = 1'b1;
          w_alloc_own[w_wr_ptr] = bus.sptag1;
          w_alloc_par[w_wr_ptr] = bus.tagreg;
          w_wr_ptr              = ptr_inc(w_wr_ptr);
          w_n_push              = w_n_push + 1;
        end else begin
          w_drop = 1'b1;
        end
      end
      if (bus.branchvalid2) begin
        if (w_n_push < w_space) begin
          w_alloc[w_wr_ptr]     = 1'b1;
          w_alloc_own[w_wr_ptr] = bus.sptag2;
          w_alloc_par[w_wr_ptr] = bus.sptag1;
          w_wr_ptr              = ptr_inc(w_wr_ptr);
          w_n_push              = w_n_push + 1;
        end else begin
          w_drop = 1'b1;
        end
      end
    end
  end

  always_comb begin
    head_d     = head_q;
    tail_d     = w_wr_ptr;
    count_d    = CNT_LEN'(int'(count_q) + w_n_push - (w_retire_ok ? 1 : 0));
    overflow_d = overflow_q | w_drop;
    if (w_retire_miss) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else if (w_retire_ok) begin
      head_d = ptr_inc(head_q);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  generate
    for (genvar g = 0; g < BRANCH_ENT_NUM; g++) begin : g_entry
      logic w_pop;
      assign w_pop = w_retire_ok && (head_q == PTR_LEN'(g));

      brq_entry #(
        .TAG_LEN (SPECTAG_LEN),
        .ADDR_W  (ADDR_LEN)
      ) u_entry (
        .clk            (clk),
        .reset          (reset),
        .flush_i        (w_retire_miss),
        .alloc_i        (w_alloc[g]),
        .alloc_own_i    (w_alloc_own[g]),
        .alloc_parent_i (w_alloc_par[g]),
        .pop_i          (w_pop),
        .exe_valid_i    (bus.exe_valid),
        .exe_tag_i      (bus.exe_tag),
        .exe_miss_i     (bus.exe_miss),
        .exe_target_i   (bus.exe_target),
        .valid_o        (ent_valid[g]),
        .own_o          (ent_own[g]),
        .parent_o       (ent_parent[g]),
        .resolved_o     (ent_resolved[g]),
        .miss_o         (ent_miss[g]),
        .target_o       (ent_target[g])
      );
    end
  endgenerate

  assign bus.prsuccess = w_retire_ok;
  assign bus.prmiss    = w_retire_miss;
  assign bus.tagregfix = w_retire_miss ? ent_parent[head_q] : '0;
  assign bus.kill_mask = w_retire_miss ? w_kill : '0;
  assign bus.prmiss_pc = w_retire_miss ? ent_target[head_q] : '0;
  assign bus.empty     = (count_q == '0);
  assign bus.overflow  = overflow_q;

endmodule : spectag_resolver
`default_nettype wire

// File: tb/tb_spectag_resolver.sv
`default_nettype none
// ============================================================================
// Module      : tb_spectag_resolver
// Description : Self-checking bench for spectag_resolver. Directed scenarios
//               followed by randomized dispatch/outcome traffic, compared
//               against a queue-based reference model of the branch queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spectag_resolver;
  import spectag_resolver_pkg::*;

  localparam int N = BRANCH_ENT_NUM;
  localparam int T = SPECTAG_LEN;
  localparam int A = ADDR_LEN;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  spectag_resolver_if #(.TAG_LEN(T), .ADDR_W(A)) bus ();

  spectag_resolver #(
    .SPECTAG_LEN    (T),
    .BRANCH_ENT_NUM (N),
    .ADDR_LEN       (A)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [T-1:0] own;
    logic [T-1:0] parent;
    bit           resolved;
    bit           miss;
    logic [A-1:0] target;
  } ent_t;

  ent_t mq[$];
  bit   m_ovf;
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Expected outputs follow directly from the oldest outstanding branch.
  task automatic check_outputs(input string tag);
    bit           e_s, e_m;
    logic [T-1:0] e_kill, e_fix;
    logic [A-1:0] e_pc;
    e_s = 0; e_m = 0; e_kill = '0; e_fix = '0; e_pc = '0;
    if (mq.size() > 0 && mq[0].resolved) begin
      e_s = !mq[0].miss;
      e_m =  mq[0].miss;
    end
    if (e_m) begin
      foreach (mq[i]) e_kill |= mq[i].own;
      e_fix = mq[0].parent;
      e_pc  = mq[0].target;
    end
    chk({tag, ".prsuccess"}, bus.prsuccess, e_s);
    chk({tag, ".prmiss"},    bus.prmiss,    e_m);
    chk({tag, ".tagregfix"}, bus.tagregfix, e_fix);
    chk({tag, ".kill_mask"}, bus.kill_mask, e_kill);
    chk({tag, ".prmiss_pc"}, bus.prmiss_pc, e_pc);
    chk({tag, ".empty"},     bus.empty,     mq.size() == 0);
    chk({tag, ".overflow"},  bus.overflow,  m_ovf);
  endtask

  task automatic model_push(input logic [T-1:0] own, input logic [T-1:0] parent);
    ent_t e;
    if (mq.size() < N) begin
      e.own = own; e.parent = parent; e.resolved = 0; e.miss = 0; e.target = '0;
      mq.push_back(e);
    end else begin
      m_ovf = 1;
    end
  endtask

  // Applies one clock edge to the model using the inputs held across it.
  task automatic model_edge();
    bit s, m;
    if (!reset) begin
      mq.delete();
      m_ovf = 0;
      return;
    end
    s = mq.size() > 0 && mq[0].resolved && !mq[0].miss;
    m = mq.size() > 0 && mq[0].resolved &&  mq[0].miss;
    if (bus.exe_valid) begin
      foreach (mq[i]) begin
        if (mq[i].own == bus.exe_tag) begin
          mq[i].resolved = 1;
          mq[i].miss     = bus.exe_miss;
          mq[i].target   = bus.exe_target;
        end
      end
    end
    if (m) mq.delete();
    else if (s) void'(mq.pop_front());
    if (bus.enable && !m) begin
      if (bus.branchvalid1) model_push(bus.sptag1, bus.tagreg);
      if (bus.branchvalid2) model_push(bus.sptag2, bus.sptag1);
    end
  endtask

  task automatic cycle(input string tag);
    check_outputs(tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    bus.enable = 0; bus.branchvalid1 = 0; bus.branchvalid2 = 0;
    bus.tagreg = '0; bus.sptag1 = '0; bus.sptag2 = '0;
    bus.exe_valid = 0; bus.exe_tag = '0; bus.exe_miss = 0; bus.exe_target = '0;
  endtask

  task automatic disp(input bit v1, input bit v2, input logic [T-1:0] tr,
                      input logic [T-1:0] s1, input logic [T-1:0] s2);
    bus.enable = 1; bus.branchvalid1 = v1; bus.branchvalid2 = v2;
    bus.tagreg = tr; bus.sptag1 = s1; bus.sptag2 = s2;
  endtask

  task automatic exe(input logic [T-1:0] tag, input bit miss, input logic [A-1:0] tgt);
    bus.exe_valid = 1; bus.exe_tag = tag; bus.exe_miss = miss; bus.exe_target = tgt;
  endtask

  // Reset is asserted away from any edge and takes effect immediately.
  task automatic do_reset(input string tag);
    reset = 0;
    #1;
    mq.delete();
    m_ovf = 0;
    check_outputs(tag);
    @(posedge clk);
    @(negedge clk);
    check_outputs(tag);
    reset = 1;
  endtask

  function automatic logic [T-1:0] onehot();
    logic [T-1:0] one;
    one = 1;
    return one << $urandom_range(T - 1, 0);
  endfunction

  task automatic random_phase(input int cycles, input int en_pct);
    for (int c = 0; c < cycles; c++) begin
      idle();
      if ($urandom_range(99, 0) < en_pct) begin
        disp(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), onehot(), onehot(), onehot());
      end
      if (mq.size() > 0 && $urandom_range(99, 0) < 60) begin
        exe(mq[$urandom_range(mq.size() - 1, 0)].own, $urandom_range(3, 0) == 0, $urandom);
      end else if ($urandom_range(9, 0) == 0) begin
        exe(onehot(), 1'($urandom_range(1, 0)), $urandom);
      end
      cycle("rand");
    end
  endtask

  initial begin
    idle();
    @(negedge clk);
    do_reset("reset");
    chk("reset.empty_lit", bus.empty, 1);

    // Single branch, correctly predicted.
    idle(); disp(1, 0, 5'b00001, 5'b00010, '0); cycle("tc1.disp");
    idle(); exe(5'b00010, 0, '0);                cycle("tc1.exe");
    idle();
    chk("tc1.prsuccess_lit", bus.prsuccess, 1);
    cycle("tc1.ret");
    chk("tc1.empty_lit", bus.empty, 1);

    // Out-of-order resolve: younger miss held until older retires.
    idle(); disp(1, 1, 5'b00001, 5'b00010, 5'b00100); cycle("tc2.disp");
    idle(); exe(5'b00100, 1, 32'h400);                cycle("tc2.exe_young");
    chk("tc2.no_retire_lit", bus.prmiss | bus.prsuccess, 0);
    idle(); exe(5'b00010, 0, '0);                     cycle("tc2.exe_old");
    idle();
    chk("tc2.prsuccess_lit", bus.prsuccess, 1);
    cycle("tc2.ret_old");
    chk("tc2.prmiss_lit", bus.prmiss, 1);
    chk("tc2.tagregfix_lit", bus.tagregfix, 5'b00010);
    chk("tc2.kill_lit", bus.kill_mask, 5'b00100);
    chk("tc2.pc_lit", bus.prmiss_pc, 32'h400);
    cycle("tc2.ret_young");

    // Head mispredict with 4 outstanding.
    idle(); disp(1, 1, 5'b00001, 5'b00010, 5'b00100); cycle("tc3.disp_a");
    idle(); disp(1, 1, 5'b00100, 5'b01000, 5'b10000); cycle("tc3.disp_b");
    idle(); exe(5'b00010, 1, 32'h123);                cycle("tc3.exe");
    idle();
    chk("tc3.prmiss_lit", bus.prmiss, 1);
    chk("tc3.tagregfix_lit", bus.tagregfix, 5'b00001);
    chk("tc3.kill_lit", bus.kill_mask, 5'b11110);
    cycle("tc3.flush");
    chk("tc3.empty_lit", bus.empty, 1);

    // Push alongside prsuccess on a full queue, then overflow.
    idle(); disp(1, 1, 5'b00001, 5'b00010, 5'b00100); cycle("tc4.disp_a");
    idle(); disp(1, 1, 5'b00100, 5'b01000, 5'b10000); cycle("tc4.disp_b");
    idle(); exe(5'b00010, 0, '0);                     cycle("tc4.exe");
    idle(); disp(1, 0, 5'b10000, 5'b00010, '0);
    chk("tc4.prsuccess_lit", bus.prsuccess, 1);
    cycle("tc4.push_pop");
    chk("tc4.overflow_lit", bus.overflow, 0);
    idle(); disp(1, 0, 5'b00010, 5'b00100, '0);       cycle("tc5.push_full");
    chk("tc5.overflow_lit", bus.overflow, 1);
    idle(); cycle("tc5.hold1"); cycle("tc5.hold2");
    exe(5'b00100, 1, 32'habc);                        cycle("tc5.exe");
    idle();
    chk("tc5.kill_lit", bus.kill_mask, 5'b11110);
    chk("tc5.tagregfix_lit", bus.tagregfix, 5'b00010);
    chk("tc5.pc_lit", bus.prmiss_pc, 32'habc);
    cycle("tc5.flush");
    chk("tc5.sticky_lit", bus.overflow, 1);

    // Async reset with 3 outstanding, head already resolved.
    idle(); disp(1, 1, 5'b00001, 5'b00010, 5'b00100); cycle("tc6.disp_a");
    idle(); disp(1, 0, 5'b00100, 5'b01000, '0);       cycle("tc6.disp_b");
    idle(); exe(5'b00010, 0, '0);                     cycle("tc6.exe");
    idle();
    chk("tc6.pre_prsuccess_lit", bus.prsuccess, 1);
    #2;
    do_reset("tc6.reset");
    chk("tc6.overflow_cleared_lit", bus.overflow, 0);
    idle(); exe(5'b00100, 0, '0);                     cycle("tc6.stale");
    idle();
    chk("tc6.stale_lit", bus.prsuccess | bus.prmiss, 0);
    cycle("tc6.after");

    // Randomized traffic: heavy dispatch, then light dispatch after reset.
    random_phase(300, 70);
    idle(); @(negedge clk);
    do_reset("mid.reset");
    random_phase(300, 25);

    idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_spectag_resolver
`default_nettype wire
